imm_gen_pipe: RTL and testbench

- Registered, handshaked immediate generator for the decode stage, successor to the combinational immediate unit.
- Generalised in three ways: XLEN parameter (RV32/RV64), two extra immediate kinds (CSR zimm, shift amount), and a tag carried alongside each result.
- Adds a valid/ready pipeline stage with an optional skid buffer, flush, and a saturating illegal-select counter.
- Sits between instruction fetch/decode control and the ID/EX register.

---
 rtl/imm_gen_pipe_if.sv | 27 ++
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle between decode control, the immediate stage and ID/EX.
// The master side drives instructions in and accepts results out.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [2:0]       in_immsel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_inst, in_immsel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_inst, in_immsel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake, optional
// skid entry, flush and a saturating reserved-select counter.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int SKID  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    imm_gen_pipe_if.slave    bus,
    output logic [CNT_W-1:0] err_count
);
    localparam int W = XLEN + TAG_W + 1;

    if ((XLEN != 32 && XLEN != 64) || SKID < 0 || SKID > 1) begin : g_bad_param
        $error("imm_gen_pipe: unsupported XLEN or SKID");
    end

    logic [31:0]      w_i;
    logic [31:0]      w_i32;
    logic             w_err;
    logic [XLEN-1:0]  w_imm;
    logic [W-1:0]     w_ent;
    logic             w_acc;
    logic             w_emit;
    logic             w_unused_opc;
    logic             r_m_v;
    logic [W-1:0]     r_m;
    logic [CNT_W-1:0] r_cnt;

    assign w_i          = bus.in_inst;
    assign w_unused_opc = ^w_i[6:0];

    // Sign-extended kinds carry inst[31] in bit 31; zero-extended ones leave it 0.
    always_comb begin
        w_i32 = '0;
        w_err = 1'b0;
        unique case (bus.in_immsel)
            3'd0: w_i32 = {w_i[31:12], 12'b0};
            3'd1: w_i32 = {{20{w_i[31]}}, w_i[31:20]};
            3'd2: w_i32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
            3'd3: w_i32 = {{19{w_i[31]}}, w_i[31], w_i[7],
                           w_i[30:25], w_i[11:8], 1'b0};
            3'd4: w_i32 = {{11{w_i[31]}}, w_i[31], w_i[19:12],
                           w_i[20], w_i[30:21], 1'b0};
            3'd5: w_i32 = {27'b0, w_i[19:15]};
            3'd6: w_i32 = (XLEN == 64) ? {26'b0, w_i[25:20]}
                                       : {27'b0, w_i[24:20]};
            default: w_err = 1'b1;
        endcase
        w_imm       = {XLEN{w_i32[31]}};
        w_imm[31:0] = w_i32;
    end

    assign w_ent  = {w_err, bus.in_tag, w_imm};
    assign w_acc  = bus.in_valid & bus.in_ready;
    assign w_emit = r_m_v & bus.out_ready;

    assign bus.out_valid = r_m_v;
    assign {bus.out_err, bus.out_tag, bus.out_imm} = r_m;
    assign err_count = r_cnt;

    if (SKID == 1) begin : g_skid
        logic         r_s_v;
        logic [W-1:0] r_s;
        logic         r_rdy;
        logic         w_s_nxt;

        assign w_s_nxt = r_s_v ? !w_emit : (w_acc & r_m_v & !w_emit);
        assign bus.in_ready = r_rdy;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_m_v <= 1'b0;
                r_s_v <= 1'b0;
                r_rdy <= 1'b1;
                r_m   <= '0;
            end else if (flush) begin
                r_m_v <= 1'b0;
                r_s_v <= 1'b0;
                r_rdy <= 1'b1;
            end else begin
                r_s_v <= w_s_nxt;
                r_rdy <= !w_s_nxt;
                r_m_v <= r_s_v | w_acc | (r_m_v & !w_emit);
                // A full skid blocks accepts, so it always refills main first.
                if (w_emit && r_s_v)
                    r_m <= r_s;
                else if (w_acc && (!r_m_v || w_emit))
                    r_m <= w_ent;
                if (w_acc && r_m_v && !w_emit)
                    r_s <= w_ent;
            end
        end
    end else begin : g_reg
        assign bus.in_ready = !r_m_v | bus.out_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_m_v <= 1'b0;
                r_m   <= '0;
            end else if (flush) begin
                r_m_v <= 1'b0;
            end else if (w_acc) begin
                r_m_v <= 1'b1;
                r_m   <= w_ent;
            end else if (w_emit) begin
                r_m_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (!flush && w_acc && w_err && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 with skid entry and RV64 single-register
// instances share one stimulus stream and are checked against queue models.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fl = 1'b0;
    logic        v = 1'b0;
    logic [31:0] inst = '0;
    logic [2:0]  sel = '0;
    logic [3:0]  tag = '0;
    logic        ordy = 1'b0;
    logic [7:0]  cnt32_o;
    logic [7:0]  cnt64_o;
    logic        started = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) if64 ();

    assign if32.in_valid  = v;
    assign if32.in_inst   = inst;
    assign if32.in_immsel = sel;
    assign if32.in_tag    = tag;
    assign if32.out_ready = ordy;
    assign if64.in_valid  = v;
    assign if64.in_inst   = inst;
    assign if64.in_immsel = sel;
    assign if64.in_tag    = tag;
    assign if64.out_ready = ordy;

    imm_gen_pipe #(.XLEN(32), .TAG_W(4), .SKID(1), .CNT_W(8)) u32 (
        .clk(clk), .rst(rst), .flush(fl), .bus(if32), .err_count(cnt32_o)
    );
    imm_gen_pipe #(.XLEN(64), .TAG_W(4), .SKID(0), .CNT_W(8)) u64 (
        .clk(clk), .rst(rst), .flush(fl), .bus(if64), .err_count(cnt64_o)
    );

    typedef struct {
        logic [63:0] imm;
        logic [3:0]  tag;
        logic        err;
    } res_t;

    res_t q32[$];
    res_t q64[$];
    int   cnt32 = 0;
    int   cnt64 = 0;

    // Immediate value from the encoding tables, as signed arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] i,
                                            input logic [2:0] s,
                                            input int xl);
        longint      sv;
        longint      hi;
        logic [63:0] r;
        sv = longint'($signed(i));
        case (s)
            3'd0: r = sv & ~64'hFFF;
            3'd1: r = sv >>> 20;
            3'd2: begin
                hi = sv >>> 25;
                r  = (hi << 5) | 64'(i[11:7]);
            end
            3'd3: begin
                hi = sv >>> 31;
                r  = (hi << 12) | (64'(i[7]) << 11)
                   | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
            end
            3'd4: begin
                hi = sv >>> 31;
                r  = (hi << 20) | (64'(i[19:12]) << 12)
                   | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
            end
            3'd5: r = 64'(i[19:15]);
            3'd6: r = (xl == 32) ? 64'(i[24:20]) : 64'(i[25:20]);
            default: r = '0;
        endcase
        if (xl == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    function automatic res_t mk(input int xl);
        res_t e;
        e.imm = ref_imm(inst, sel, xl);
        e.tag = tag;
        e.err = (sel == 3'd7);
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit a32, a64, e32, e64;
        if (rst) begin
            started = 1'b1;
            q32.delete();
            q64.delete();
            cnt32 = 0;
            cnt64 = 0;
        end else if (fl) begin
            q32.delete();
            q64.delete();
        end else begin
            a32 = v && (q32.size() < 2);
            e32 = (q32.size() > 0) && ordy;
            a64 = v && ((q64.size() == 0) || ordy);
            e64 = (q64.size() > 0) && ordy;
            if (e32) void'(q32.pop_front());
            if (e64) void'(q64.pop_front());
            if (a32) begin
                q32.push_back(mk(32));
                if (sel == 3'd7 && cnt32 < 255) cnt32++;
            end
            if (a64) begin
                q64.push_back(mk(64));
                if (sel == 3'd7 && cnt64 < 255) cnt64++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("m32_valid", if32.out_valid, q32.size() > 0);
            check("m32_ready", if32.in_ready, q32.size() < 2);
            check("m32_cnt", cnt32_o, cnt32);
            if (q32.size() > 0) begin
                check("m32_imm", {32'b0, if32.out_imm}, q32[0].imm);
                check("m32_tag", if32.out_tag, q32[0].tag);
                check("m32_err", if32.out_err, q32[0].err);
            end
            check("m64_valid", if64.out_valid, q64.size() > 0);
            check("m64_ready", if64.in_ready, (q64.size() == 0) || ordy);
            check("m64_cnt", cnt64_o, cnt64);
            if (q64.size() > 0) begin
                check("m64_imm", if64.out_imm, q64[0].imm);
                check("m64_tag", if64.out_tag, q64[0].tag);
                check("m64_err", if64.out_err, q64[0].err);
            end
        end
    end

    task automatic cyc(input logic v_, input logic [31:0] i_,
                       input logic [2:0] s_, input logic [3:0] t_,
                       input logic r_, input logic f_);
        #1;
        v = v_; inst = i_; sel = s_; tag = t_; ordy = r_; fl = f_;
        @(negedge clk);
    endtask

    task automatic reset_vals(input string p);
        check({p, "_v32"}, if32.out_valid, 0);
        check({p, "_imm32"}, if32.out_imm, 0);
        check({p, "_tag32"}, if32.out_tag, 0);
        check({p, "_err32"}, if32.out_err, 0);
        check({p, "_cnt32"}, cnt32_o, 0);
        check({p, "_rdy32"}, if32.in_ready, 1);
        check({p, "_v64"}, if64.out_valid, 0);
        check({p, "_imm64"}, if64.out_imm, 0);
        check({p, "_tag64"}, if64.out_tag, 0);
        check({p, "_err64"}, if64.out_err, 0);
        check({p, "_cnt64"}, cnt64_o, 0);
        check({p, "_rdy64"}, if64.in_ready, 1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset_vals("reset");
        #1 rst = 1'b0;
        @(negedge clk);

        check("pin_b", ref_imm(32'hFE000EE3, 3'd3, 32), 64'hFFFF_FFFC);
        check("pin_u", ref_imm(32'h800000B7, 3'd0, 64), 64'hFFFF_FFFF_8000_0000);
        check("pin_sh", ref_imm(32'h03F01093, 3'd6, 64), 64'h3F);
        check("pin_s", ref_imm(32'hFE112E23, 3'd2, 32), 64'hFFFF_FFFC);

        cyc(1, 32'hFE000EE3, 3'd3, 4'd5, 1, 0);
        check("b_imm32", {32'b0, if32.out_imm}, 64'hFFFF_FFFC);
        check("b_imm64", if64.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("b_tag32", if32.out_tag, 4'd5);
        check("b_err32", if32.out_err, 0);
        cyc(1, 32'h800000B7, 3'd0, 4'd6, 1, 0);
        check("u_imm64", if64.out_imm, 64'hFFFF_FFFF_8000_0000);
        check("u_imm32", {32'b0, if32.out_imm}, 64'h8000_0000);
        cyc(1, 32'h03F01093, 3'd6, 4'd7, 1, 0);
        check("sh_imm64", if64.out_imm, 64'h3F);
        check("sh_imm32", {32'b0, if32.out_imm}, 64'h1F);
        cyc(0, 32'h0, 3'd0, 4'd0, 1, 0);

        cyc(1, 32'h00A00093, 3'd1, 4'd1, 0, 0);
        check("sk_tag1", if32.out_tag, 4'd1);
        cyc(1, 32'h00B00093, 3'd1, 4'd2, 0, 0);
        check("sk_full", if32.in_ready, 0);
        cyc(1, 32'h00C00093, 3'd1, 4'd3, 0, 0);
        check("sk_hold_rdy", if32.in_ready, 0);
        check("sk_hold_tag", if32.out_tag, 4'd1);
        cyc(1, 32'h00C00093, 3'd1, 4'd3, 1, 0);
        check("sk_tag2", if32.out_tag, 4'd2);
        check("sk_rdy2", if32.in_ready, 1);
        cyc(1, 32'h00C00093, 3'd1, 4'd3, 1, 0);
        check("sk_tag3", if32.out_tag, 4'd3);
        check("sk_imm3", {32'b0, if32.out_imm}, 64'hC);
        cyc(0, 32'h0, 3'd0, 4'd0, 1, 0);

        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'h12345678 ^ (i * 32'h9E3779B9), 3'(i), 4'(i), 1, 0);
            check("st_v32", if32.out_valid, 1);
            check("st_tag32", if32.out_tag, 4'(i));
            check("st_v64", if64.out_valid, 1);
            check("st_tag64", if64.out_tag, 4'(i));
        end
        cyc(0, 32'h0, 3'd0, 4'd0, 1, 0);

        for (int i = 0; i < 3; i++)
            cyc(1, 32'hFFF00093, 3'd1, 4'd9, 0, 0);
        cyc(1, 32'h0, 3'd7, 4'd10, 0, 1);
        check("fl_v32", if32.out_valid, 0);
        check("fl_rdy32", if32.in_ready, 1);
        check("fl_cnt32", cnt32_o, 1);
        check("fl_v64", if64.out_valid, 0);
        check("fl_rdy64", if64.in_ready, 1);
        check("fl_cnt64", cnt64_o, 1);
        cyc(1, 32'h0, 3'd7, 4'd11, 1, 1);
        check("fla_v32", if32.out_valid, 0);
        check("fla_cnt32", cnt32_o, 1);
        check("fla_cnt64", cnt64_o, 1);

        for (int i = 0; i < 300; i++)
            cyc(1, $urandom, 3'd7, 4'(i), 1, 0);
        check("sat_cnt32", cnt32_o, 255);
        check("sat_cnt64", cnt64_o, 255);
        check("sat_err32", if32.out_err, 1);
        check("sat_imm64", if64.out_imm, 0);
        cyc(0, 32'h0, 3'd0, 4'd0, 1, 0);

        cyc(1, 32'hFE112E23, 3'd2, 4'd12, 0, 0);
        cyc(1, 32'hFE112E23, 3'd2, 4'd13, 0, 0);
        #1 rst = 1'b1;
        @(negedge clk);
        reset_vals("midrst");
        #1 rst = 1'b0; v = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
